// File: rtl/multiplier_shift_add_64b.sv
// Iterative radix-2 shift-add 64x64->128 unsigned multiplier with valid/ready handshakes.
// Optional MUL_ZERO_BYPASS_EN: zero operands skip the iteration loop and complete immediately.

module carry_lookahead_adder_64b (
    input  logic [63:0] operand1_i,
    input  logic [63:0] operand2_i,
    input  logic        carry_i,
    output logic [63:0] sum_o,
    output logic        carry_o
);

    logic [63:0] gen;
    logic [63:0] prop;
    logic [63:0] carry;
    logic [16:0] group_carry;
    logic [15:0] group_gen;
    logic [15:0] group_prop;

    assign gen  = operand1_i & operand2_i;
    assign prop = operand1_i ^ operand2_i;

    // 4-bit lookahead groups; group carries resolved from group generate/propagate terms.
    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            group_gen[i]  = gen[4*i+3]
                          | (prop[4*i+3] & gen[4*i+2])
                          | (prop[4*i+3] & prop[4*i+2] & gen[4*i+1])
                          | (prop[4*i+3] & prop[4*i+2] & prop[4*i+1] & gen[4*i]);
            group_prop[i] = &prop[4*i +: 4];
        end
    end

    always_comb begin
        group_carry[0] = carry_i;
        for (int unsigned i = 0; i < 16; i++) begin
            group_carry[i+1] = group_gen[i] | (group_prop[i] & group_carry[i]);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            carry[4*i]   = group_carry[i];
            carry[4*i+1] = gen[4*i]   | (prop[4*i]   & group_carry[i]);
            carry[4*i+2] = gen[4*i+1] | (prop[4*i+1] & gen[4*i])
                         | (prop[4*i+1] & prop[4*i] & group_carry[i]);
            carry[4*i+3] = gen[4*i+2] | (prop[4*i+2] & gen[4*i+1])
                         | (prop[4*i+2] & prop[4*i+1] & gen[4*i])
                         | (prop[4*i+2] & prop[4*i+1] & prop[4*i] & group_carry[i]);
        end
    end

    assign sum_o   = prop ^ carry;
    assign carry_o = group_carry[16];

endmodule

module multiplier_shift_add_64b #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [WIDTH-1:0]     multiplicand_i,
    input  logic [WIDTH-1:0]     multiplier_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [2*WIDTH-1:0]   product_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [WIDTH-1:0]     acc_hi_q;
    logic [WIDTH-1:0]     acc_lo_q;
    logic [5:0]           cnt_q;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     add_sum;
    logic                 add_carry;
    logic [WIDTH:0]       partial;
    logic [2*WIDTH-1:0]   shifted;
    logic                 accept;

    carry_lookahead_adder_64b u_adder (
        .operand1_i (acc_hi_q),
        .operand2_i (mcand_q),
        .carry_i    (1'b0),
        .sum_o      (add_sum),
        .carry_o    (add_carry)
    );

    assign ready_o   = (state_q == IDLE);
    assign valid_o   = (state_q == DONE);
    assign product_o = product_q;
    assign accept    = valid_i && ready_o;

    // 129-bit {carry, sum, acc_lo} shifted right by one; the dropped bit is acc_lo[0].
    assign partial = acc_lo_q[0] ? {add_carry, add_sum} : {1'b0, acc_hi_q};
    assign shifted = {partial, acc_lo_q[WIDTH-1:1]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mcand_q  <= multiplicand_i;
                        acc_hi_q <= '0;
                        acc_lo_q <= multiplier_i;
                        cnt_q    <= '0;
`ifdef MUL_ZERO_BYPASS_EN
                        if ((multiplicand_i == '0) || (multiplier_i == '0)) begin
                            product_q <= '0;
                            state_q   <= DONE;
                        end else begin
                            state_q   <= BUSY;
                        end
`else
                        state_q  <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    acc_hi_q <= shifted[2*WIDTH-1:WIDTH];
                    acc_lo_q <= shifted[WIDTH-1:0];
                    cnt_q    <= cnt_q + 6'd1;
                    if (cnt_q == 6'd63) begin
                        product_q <= shifted;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_shift_add_64b.sv
// Directed self-checking bench for multiplier_shift_add_64b using immediate assertions.
module tb_multiplier_shift_add_64b;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         valid_i;
    logic         ready_o;
    logic [63:0]  multiplicand_i;
    logic [63:0]  multiplier_i;
    logic         valid_o;
    logic         ready_i;
    logic [127:0] product_o;

    int checks = 0;
    int errors = 0;

    multiplier_shift_add_64b #(.WIDTH(64)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .multiplicand_i (multiplicand_i),
        .multiplier_i   (multiplier_i),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .product_o      (product_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic accept(input logic [63:0] a, input logic [63:0] b);
        @(negedge clk_i);
        multiplicand_i = a;
        multiplier_i   = b;
        valid_i        = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (valid_o !== 1'b1 && lat < 200) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int highs;
        rst_i          = 1'b1;
        valid_i        = 1'b0;
        ready_i        = 1'b0;
        multiplicand_i = '0;
        multiplier_i   = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", 128'(ready_o), 128'd1);
        check("rst_valid", 128'(valid_o), 128'd0);
        check("rst_product", product_o, 128'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // 3 x 5
        ready_i = 1'b1;
        accept(64'd3, 64'd5);
        check("busy_ready", 128'(ready_o), 128'd0);
        wait_valid(lat);
        check("3x5_latency", 128'(lat), 128'd64);
        check("3x5_product", product_o, 128'd15);
        check("3x5_ready_in_done", 128'(ready_o), 128'd0);
        @(posedge clk_i);
        #1;
        check("3x5_back_idle", 128'(ready_o), 128'd1);
        check("3x5_valid_low", 128'(valid_o), 128'd0);

        // all-ones squared
        accept(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_valid(lat);
        check("sq_latency", 128'(lat), 128'd64);
        check("sq_product", product_o, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        @(posedge clk_i);
        #1;

        // backpressure
        ready_i = 1'b0;
        accept(64'h1_0000_0000, 64'h1_0000_0000);
        wait_valid(lat);
        check("bp_latency", 128'(lat), 128'd64);
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_hold", 128'(valid_o), 128'd1);
            check("bp_product_hold", product_o, 128'h1_0000_0000_0000_0000);
            check("bp_ready_low", 128'(ready_o), 128'd0);
            @(posedge clk_i);
            #1;
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        check("bp_release_idle", 128'(ready_o), 128'd1);
        check("bp_release_valid", 128'(valid_o), 128'd0);

        // valid_i ignored during BUSY and DONE
        accept(64'd6, 64'd7);
        repeat (10) @(posedge clk_i);
        #1;
        multiplicand_i = 64'd100;
        multiplier_i   = 64'd100;
        valid_i        = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        wait_valid(lat);
        check("ign_latency", 128'(lat + 11), 128'd64);
        check("ign_product", product_o, 128'd42);
        multiplicand_i = 64'd3;
        multiplier_i   = 64'd3;
        valid_i        = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        check("ign_done_valid", 128'(valid_o), 128'd1);
        check("ign_done_product", product_o, 128'd42);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        check("ign_idle", 128'(ready_o), 128'd1);
        highs = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk_i);
            #1;
            if (valid_o === 1'b1) highs++;
        end
        check("ign_no_second_result", 128'(highs), 128'd0);
        check("ign_product_kept", product_o, 128'd42);

        // async reset mid-BUSY
        ready_i = 1'b1;
        accept(64'd7, 64'd9);
        repeat (20) @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        check("arst_ready", 128'(ready_o), 128'd1);
        check("arst_valid", 128'(valid_o), 128'd0);
        check("arst_product", product_o, 128'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        accept(64'd7, 64'd9);
        wait_valid(lat);
        check("7x9_latency", 128'(lat), 128'd64);
        check("7x9_product", product_o, 128'd63);
        @(posedge clk_i);
        #1;

        // zero operand
        ready_i = 1'b0;
        accept(64'd0, 64'h1234);
        wait_valid(lat);
`ifdef MUL_ZERO_BYPASS_EN
        check("zero_latency_bypass", 128'(lat <= 1), 128'd1);
`else
        check("zero_latency", 128'(lat), 128'd64);
`endif
        check("zero_product", product_o, 128'd0);
        check("zero_valid", 128'(valid_o), 128'd1);
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        check("zero_back_idle", 128'(ready_o), 128'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
